// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and helpers for the NoC injection arbiter
package noc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } inj_state_t;

    // Counter must hold every value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// rtl/noc_inject_arbiter_rr_arbiter.sv - combinational round-robin pick, first request after ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    always_comb begin
        int w_j;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_j         = 0;
        // Scan starts one past the pointer so the last winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_grant_idx  = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-atomic round-robin sharing of one router injection port
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [FLIT_WIDTH-1:0] req_data    [NUM_REQ],
    input  logic [DEST_WIDTH-1:0] req_dest    [NUM_REQ],
    input  logic [NUM_REQ-1:0]    req_is_tail,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = credit_width(FLIT_BUFFER_DEPTH);
    localparam logic [CW-1:0]    CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

    inj_state_t             r_state;
    inj_state_t             w_state_nxt;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [CW-1:0]          r_credit_cnt;
    logic [FLIT_WIDTH-1:0]  r_data;
    logic [DEST_WIDTH-1:0]  r_dest;
    logic                   r_tail;
    logic                   r_send;

    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_any;
    logic [IDX_W-1:0]       w_sel;
    logic                   w_can_send;
    logic                   w_accept;
    logic                   w_sel_tail;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_grant_any)
    );

    // Credit is gated on the registered count only; a same-cycle credit_in never opens ready.
    assign w_can_send = (r_credit_cnt != '0);
    assign w_accept   = |req_ready;
    assign w_sel_tail = req_is_tail[w_sel];

    always_comb begin
        req_ready = '0;
        w_sel     = r_owner;
        case (r_state)
            IDLE: begin
                w_sel = w_grant_idx;
                if (w_can_send && w_grant_any) begin
                    req_ready = w_grant_oh;
                end
            end
            LOCKED: begin
                req_ready[r_owner] = w_can_send & req_valid[r_owner];
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_sel_tail) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (w_accept && w_sel_tail) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= PTR_RESET;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept) begin
                r_owner  <= w_grant_idx;
                r_rr_ptr <= w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit_cnt <= CREDIT_MAX;
        end else begin
            case ({w_accept, credit_in})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    if (r_credit_cnt != CREDIT_MAX) begin
                        r_credit_cnt <= r_credit_cnt + 1'b1;
                    end
                end
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_send <= 1'b0;
            r_data <= '0;
            r_dest <= '0;
            r_tail <= 1'b0;
        end else begin
            r_send <= w_accept;
            if (w_accept) begin
                r_data <= req_data[w_sel];
                r_dest <= req_dest[w_sel];
                r_tail <= w_sel_tail;
            end
        end
    end

    assign send_out    = r_send;
    assign data_out    = r_data;
    assign dest_out    = r_dest;
    assign is_tail_out = r_tail;

    // A credit returned while the counter is already full means the router over-reported space.
    a_credit_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(credit_in && !w_accept && r_credit_cnt == CREDIT_MAX)
    );

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - randomized bench against a packet-level arbitration model
module tb_noc_inject_arbiter;

    localparam int N  = 4;
    localparam int FW = 128;
    localparam int DW = 6;
    localparam int D  = 4;
    localparam int CYCLES = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [FW-1:0] req_data [N];
    logic [DW-1:0] req_dest [N];
    logic [N-1:0]  req_is_tail;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in;

    always #5 clk = ~clk;

    noc_inject_arbiter #(
        .NUM_REQ           (N),
        .FLIT_WIDTH        (FW),
        .DEST_WIDTH        (DW),
        .FLIT_BUFFER_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_dest    (req_dest),
        .req_is_tail (req_is_tail),
        .data_out    (data_out),
        .dest_out    (dest_out),
        .is_tail_out (is_tail_out),
        .send_out    (send_out),
        .credit_in   (credit_in)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: credits available, packet owner (-1 = none), last winner.
    int            m_cred;
    int            m_owner;
    int            m_last;
    bit            e_send;
    logic [FW-1:0] e_data;
    logic [DW-1:0] e_dest;
    bit            e_tail;
    bit            have [N];
    int            rem  [N];
    bit            acc  [N];
    bit            did_mid_rst;
    int            sends_total;

    task automatic reset_model();
        m_cred  = D;
        m_owner = -1;
        m_last  = N - 1;
        e_send  = 1'b0;
        for (int i = 0; i < N; i++) begin
            have[i] = 1'b0;
            rem[i]  = 0;
            acc[i]  = 1'b0;
        end
        req_valid   = '0;
        req_is_tail = '0;
        credit_in   = 1'b0;
    endtask

    function automatic int credit_pct(input int cyc);
        if (cyc < 500) return 60;
        if (cyc < 700) return 0;
        if (cyc < 800) return 100;
        return 70;
    endfunction

    initial begin
        int            win;
        logic [N-1:0]  exp_rdy;
        for (int i = 0; i < N; i++) begin
            req_data[i] = '0;
            req_dest[i] = '0;
        end
        reset_model();
        did_mid_rst = 1'b0;
        sends_total = 0;
        rst_n = 1'b0;
        #1;
        check_val("rst_send", FW'(send_out), FW'(0));
        check_val("rst_data", data_out, '0);
        check_val("rst_dest", FW'(dest_out), FW'(0));
        check_val("rst_tail", FW'(is_tail_out), FW'(0));
        check_val("rst_ready", FW'(req_ready), FW'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            check_val("send_out", FW'(send_out), FW'(e_send));
            if (e_send) begin
                sends_total++;
                check_val("data_out", data_out, e_data);
                check_val("dest_out", FW'(dest_out), FW'(e_dest));
                check_val("is_tail_out", FW'(is_tail_out), FW'(e_tail));
            end

            // Asynchronous reset in the middle of a packet: outputs drop at once, lock is lost.
            if (!did_mid_rst && cyc > 900 && m_owner >= 0) begin
                did_mid_rst = 1'b1;
                rst_n = 1'b0;
                reset_model();
                #1;
                check_val("midrst_send", FW'(send_out), FW'(0));
                check_val("midrst_ready", FW'(req_ready), FW'(0));
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end

            for (int i = 0; i < N; i++) begin
                if (acc[i]) have[i] = 1'b0;
                if (!have[i] && $urandom_range(0, 3) != 0) begin
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                    have[i]        = 1'b1;
                    req_data[i]    = {$urandom(), $urandom(), $urandom(), $urandom()};
                    req_dest[i]    = DW'($urandom());
                    req_is_tail[i] = (rem[i] == 1);
                    rem[i]--;
                end
                req_valid[i] = have[i];
            end
            credit_in = (m_cred < D) && ($urandom_range(0, 99) < credit_pct(cyc));
            #1;

            win = -1;
            if (m_cred > 0) begin
                if (m_owner < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (win < 0 && have[(m_last + k) % N]) win = (m_last + k) % N;
                    end
                end else if (have[m_owner]) begin
                    win = m_owner;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            check_val("req_ready", FW'(req_ready), FW'(exp_rdy));

            for (int i = 0; i < N; i++) acc[i] = (i == win);
            if (win >= 0) begin
                if (m_owner < 0) begin
                    m_last = win;
                    if (!req_is_tail[win]) m_owner = win;
                end else if (req_is_tail[win]) begin
                    m_owner = -1;
                end
                e_data = req_data[win];
                e_dest = req_dest[win];
                e_tail = req_is_tail[win];
            end
            e_send = (win >= 0);
            if (win >= 0 && !credit_in) m_cred--;
            else if (win < 0 && credit_in) m_cred++;
        end

        @(posedge clk);
        #1;
        check_val("final_send", FW'(send_out), FW'(e_send));
        check_val("mid_reset_seen", FW'(did_mid_rst), FW'(1));
        check_val("traffic_seen", FW'(sends_total > 100), FW'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
